// File: rtl/input_vector_fifo.sv
// Show-ahead FIFO for N-lane trace vectors with eof tags: registered head
// outputs, occupancy/space status, and sticky overflow with a saturating drop count.
module input_vector_fifo #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int IB_DEPTH   = 4,
    parameter int CNT_WIDTH  = $clog2(IB_DEPTH + 1)
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           valid_in,
    input  logic                           eof_in,
    input  logic [N-1:0][DATA_WIDTH-1:0]   vector_in,
    input  logic                           ready_in,
    output logic                           valid_out,
    output logic                           eof_out,
    output logic [N-1:0][DATA_WIDTH-1:0]   vector_out,
    output logic                           ready_out,
    output logic [CNT_WIDTH-1:0]           occupancy_out,
    output logic                           overflow_out,
    output logic [15:0]                    drop_count_out
);

    localparam int                   PTR_WIDTH = (IB_DEPTH > 1) ? $clog2(IB_DEPTH) : 1;
    localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(IB_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C   = CNT_WIDTH'(IB_DEPTH);

    // Explicit wrap so non-power-of-two depths stay inside the storage range.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] ptr);
        if (ptr == PTR_LAST) begin
            return {PTR_WIDTH{1'b0}};
        end else begin
            return ptr + PTR_WIDTH'(1);
        end
    endfunction

    logic [N-1:0][DATA_WIDTH-1:0] data_mem_r [IB_DEPTH];
    logic [IB_DEPTH-1:0]          eof_mem_r;

    logic [PTR_WIDTH-1:0]         wr_ptr_r;
    logic [PTR_WIDTH-1:0]         rd_ptr_r;
    logic [CNT_WIDTH-1:0]         count_r;
    logic                         valid_r;
    logic                         eof_r;
    logic [N-1:0][DATA_WIDTH-1:0] vector_r;
    logic                         ready_r;
    logic                         overflow_r;
    logic [15:0]                  drop_count_r;

    logic                         has_space_s;
    logic                         push_s;
    logic                         drop_s;
    logic                         pop_s;
    logic [PTR_WIDTH-1:0]         wr_ptr_next_s;
    logic [PTR_WIDTH-1:0]         rd_ptr_next_s;
    logic [CNT_WIDTH-1:0]         avail_s;
    logic [CNT_WIDTH-1:0]         count_next_s;

    // Handshake decode, pointer advance and next occupancy from pre-edge state.
    always_comb begin
        has_space_s   = (count_r < DEPTH_C);
        push_s        = valid_in && has_space_s;
        drop_s        = valid_in && !has_space_s;
        pop_s         = valid_r && ready_in;
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        if (push_s) begin
            wr_ptr_next_s = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_next_s = ptr_inc(rd_ptr_r);
            avail_s       = count_r - CNT_WIDTH'(1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
            avail_s       = count_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_WIDTH'(1);
            2'b01:   count_next_s = count_r - CNT_WIDTH'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk_in) begin
        if (push_s) begin
            data_mem_r[wr_ptr_r] <= vector_in;
            eof_mem_r[wr_ptr_r]  <= eof_in;
        end
    end

    // Pointers, occupancy and overflow bookkeeping.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_r     <= {PTR_WIDTH{1'b0}};
            rd_ptr_r     <= {PTR_WIDTH{1'b0}};
            count_r      <= {CNT_WIDTH{1'b0}};
            ready_r      <= 1'b1;
            overflow_r   <= 1'b0;
            drop_count_r <= 16'h0000;
        end else begin
            wr_ptr_r <= wr_ptr_next_s;
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_next_s;
            ready_r  <= (count_next_s < DEPTH_C);
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_count_r != 16'hFFFF) begin
                    drop_count_r <= drop_count_r + 16'h0001;
                end
            end
        end
    end

    // Head register: reloads from the entry at the post-pop read pointer, so an
    // entry written at edge t is first visible after edge t+1.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_r  <= 1'b0;
            eof_r    <= 1'b0;
            vector_r <= '0;
        end else begin
            valid_r <= (avail_s != {CNT_WIDTH{1'b0}});
            if (avail_s != {CNT_WIDTH{1'b0}}) begin
                vector_r <= data_mem_r[rd_ptr_next_s];
                eof_r    <= eof_mem_r[rd_ptr_next_s];
            end
        end
    end

    assign valid_out      = valid_r;
    assign eof_out        = eof_r;
    assign vector_out     = vector_r;
    assign ready_out      = ready_r;
    assign occupancy_out  = count_r;
    assign overflow_out   = overflow_r;
    assign drop_count_out = drop_count_r;

endmodule

// File: tb/tb_input_vector_fifo.sv
// Scoreboard bench for input_vector_fifo: a depth-4 instance for the main
// scenarios and a depth-3 instance for wrap-around of a non-power-of-two depth.
module tb_input_vector_fifo;

    localparam int N = 8;
    localparam int W = 32;

    logic              clk = 1'b0;
    logic              rst_in;
    logic              valid_in;
    logic              eof_in;
    logic [N-1:0][W-1:0] vector_in;
    logic              ready_in;

    logic              valid4, eof4, ready4, ovf4;
    logic [N-1:0][W-1:0] vec4;
    logic [2:0]        occ4;
    logic [15:0]       drops4;
    logic              valid3, eof3, ready3, ovf3;
    logic [N-1:0][W-1:0] vec3;
    logic [1:0]        occ3;
    logic [15:0]       drops3;

    input_vector_fifo #(.N(N), .DATA_WIDTH(W), .IB_DEPTH(4)) dut4 (
        .clk_in(clk), .rst_in(rst_in), .valid_in(valid_in), .eof_in(eof_in),
        .vector_in(vector_in), .ready_in(ready_in), .valid_out(valid4),
        .eof_out(eof4), .vector_out(vec4), .ready_out(ready4),
        .occupancy_out(occ4), .overflow_out(ovf4), .drop_count_out(drops4)
    );

    input_vector_fifo #(.N(N), .DATA_WIDTH(W), .IB_DEPTH(3)) dut3 (
        .clk_in(clk), .rst_in(rst_in), .valid_in(valid_in), .eof_in(eof_in),
        .vector_in(vector_in), .ready_in(ready_in), .valid_out(valid3),
        .eof_out(eof3), .vector_out(vec3), .ready_out(ready3),
        .occupancy_out(occ3), .overflow_out(ovf3), .drop_count_out(drops3)
    );

    always #5 clk = ~clk;

    // Which instance is under check, and its outputs.
    logic                dsel = 1'b0;
    logic                valid_m, eof_m, ready_m, ovf_m;
    logic [N-1:0][W-1:0] vec_m;
    logic [2:0]          occ_m;
    logic [15:0]         drops_m;
    assign valid_m = dsel ? valid3 : valid4;
    assign eof_m   = dsel ? eof3   : eof4;
    assign ready_m = dsel ? ready3 : ready4;
    assign ovf_m   = dsel ? ovf3   : ovf4;
    assign vec_m   = dsel ? vec3   : vec4;
    assign occ_m   = dsel ? {1'b0, occ3} : occ4;
    assign drops_m = dsel ? drops3 : drops4;

    // Reference model: sb holds every stored entry, head first.
    logic [N*W:0] sb [$];
    int           depth = 4;
    bit           m_valid;
    bit           m_ovf;
    logic [15:0]  m_drops;
    int           npop;
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic check(input string tag, input logic [263:0] got, input logic [263:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_drops = 16'h0000;
    endtask

    // One clock: model the edge on pre-edge state, then check status after it.
    task automatic tick();
        bit          do_pop;
        bit          full;
        int          avail;
        logic [N*W:0] head;
        do_pop = m_valid && ready_in;
        full   = (sb.size() >= depth);
        if (do_pop) begin
            head = sb.pop_front();
            check("pop_data", {eof_m, vec_m}, head);
            npop++;
        end
        avail = sb.size();
        if (valid_in && !full) begin
            sb.push_back({eof_in, vector_in});
        end else if (valid_in) begin
            m_ovf = 1'b1;
            if (m_drops != 16'hFFFF) m_drops = m_drops + 16'h0001;
        end
        m_valid = (avail > 0);
        @(posedge clk);
        @(negedge clk);
        check("valid_out", valid_m, m_valid);
        check("occupancy", occ_m, sb.size());
        check("ready_out", ready_m, sb.size() < depth);
        check("overflow", ovf_m, m_ovf);
        check("drop_count", drops_m, m_drops);
    endtask

    task automatic drive(input bit v, input bit e, input bit r);
        valid_in = v;
        eof_in   = e;
        ready_in = r;
        for (int i = 0; i < N; i++) vector_in[i] = $urandom;
        tick();
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_in = 1'b0;
    endtask

    initial begin
        int start;
        rst_in    = 1'b1;
        valid_in  = 1'b0;
        eof_in    = 1'b0;
        ready_in  = 1'b0;
        vector_in = '0;
        npop      = 0;
        model_clear();
        @(negedge clk);
        do_reset();

        // Reset then idle
        check("rst_valid", valid_m, 1'b0);
        check("rst_ready", ready_m, 1'b1);
        check("rst_occ", occ_m, 3'd0);
        check("rst_ovf", ovf_m, 1'b0);
        check("rst_drops", drops_m, 16'h0000);
        check("rst_vec", {eof_m, vec_m}, 257'd0);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);

        // Single vector 0x11..0x18 with eof, two-edge latency
        valid_in = 1'b1;
        eof_in   = 1'b1;
        ready_in = 1'b1;
        for (int i = 0; i < N; i++) vector_in[i] = 32'h11 + i;
        tick();
        valid_in = 1'b0;
        eof_in   = 1'b0;
        check("lat_not_yet", valid_m, 1'b0);
        start = npop;
        tick();
        check("lat_valid", valid_m, 1'b1);
        check("lat_eof", eof_m, 1'b1);
        check("lat_lane0", vec_m[0], 32'h11);
        check("lat_lane7", vec_m[7], 32'h18);
        tick();
        check("lat_popped", npop - start, 1);
        check("lat_occ", occ_m, 3'd0);

        // Overflow: five pushes into depth 4 while stalled
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, k[0], 1'b0);
            if (k == 3) check("full_ready", ready_m, 1'b0);
        end
        check("ovf_occ", occ_m, 3'd4);
        check("ovf_flag", ovf_m, 1'b1);
        check("ovf_drops", drops_m, 16'h0001);
        start = npop;
        for (int k = 0; k < 6; k++) drive(1'b0, 1'b1, 1'b1);
        check("ovf_drained", npop - start, 4);
        check("ovf_sb_empty", sb.size(), 0);
        check("ovf_sticky", ovf_m, 1'b1);

        // Full with simultaneous write and pop: write still dropped
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        check("fullpop_occ", occ_m, 3'd3);
        check("fullpop_drops", drops_m, 16'h0002);
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 1'b1);
        check("fullpop_empty", occ_m, 3'd0);

        // Asynchronous reset mid-stream with two entries held
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check("pre_rst_occ", occ_m, 3'd2);
        valid_in = 1'b0;
        #2 rst_in = 1'b1;
        #1;
        check("async_valid", valid_m, 1'b0);
        check("async_occ", occ_m, 3'd0);
        check("async_ready", ready_m, 1'b1);
        check("async_ovf", ovf_m, 1'b0);
        check("async_drops", drops_m, 16'h0000);
        model_clear();
        @(negedge clk);
        rst_in = 1'b0;
        start = npop;
        drive(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b1);
        check("post_rst_pop", npop - start, 1);

        // Depth-3 instance: 10 vectors, ready toggling 1,0
        dsel  = 1'b1;
        depth = 3;
        do_reset();
        start = npop;
        for (int k = 0; k < 20; k++) drive(k[0] == 1'b0, k[1], k[0] == 1'b0);
        for (int k = 0; k < 12; k++) drive(1'b0, 1'b0, k[0] == 1'b0);
        check("d3_count", npop - start, 10);
        check("d3_drops", drops_m, 16'h0000);
        check("d3_empty", occ_m, 3'd0);
        // Burst of 4 into depth 3: one drop
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 1'b0);
        check("d3_full_occ", occ_m, 3'd3);
        check("d3_drop", drops_m, 16'h0001);
        start = npop;
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 1'b1);
        check("d3_drain", npop - start, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
